// File: rtl/antirrebote_canal.sv
// Single button channel: two-flop synchroniser, polarity normalisation,
// debounce counter and registered press/release/toggle outputs.
module antirrebote_canal #(
  parameter int   DEBOUNCE_CYCLES = 120000,
  parameter logic ACTIVE_LOW      = 1'b1
) (
  input  logic clk,
  input  logic rstn,
  input  logic boton,
  output logic pulsado,
  output logic flanco_on,
  output logic flanco_off,
  output logic conmuta
);

  localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic          s1_r;
  logic          s2_r;
  logic [CW-1:0] cnt_r;
  logic          pulsado_r;
  logic          on_r;
  logic          off_r;
  logic          conmuta_r;

  logic          n_s;
  logic [CW-1:0] cnt_next_s;
  logic          pulsado_next_s;
  logic          on_next_s;
  logic          off_next_s;
  logic          conmuta_next_s;

  // Debounce decision: any matching sample restarts the count.
  always_comb begin
    n_s            = s2_r ^ ACTIVE_LOW;
    cnt_next_s     = '0;
    pulsado_next_s = pulsado_r;
    on_next_s      = 1'b0;
    off_next_s     = 1'b0;
    conmuta_next_s = conmuta_r;
    if (n_s == pulsado_r) begin
      cnt_next_s = '0;
    end else if (cnt_r == CNT_LAST) begin
      cnt_next_s     = '0;
      pulsado_next_s = n_s;
      on_next_s      = n_s;
      off_next_s     = ~n_s;
      conmuta_next_s = conmuta_r ^ n_s;
    end else begin
      cnt_next_s = cnt_r + CNT_ONE;
    end
  end

  // Synchroniser loads the released level so a held button never pulses at reset release.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_r      <= ACTIVE_LOW;
      s2_r      <= ACTIVE_LOW;
      cnt_r     <= '0;
      pulsado_r <= 1'b0;
      on_r      <= 1'b0;
      off_r     <= 1'b0;
      conmuta_r <= 1'b0;
    end else begin
      s1_r      <= boton;
      s2_r      <= s1_r;
      cnt_r     <= cnt_next_s;
      pulsado_r <= pulsado_next_s;
      on_r      <= on_next_s;
      off_r     <= off_next_s;
      conmuta_r <= conmuta_next_s;
    end
  end

  assign pulsado    = pulsado_r;
  assign flanco_on  = on_r;
  assign flanco_off = off_r;
  assign conmuta    = conmuta_r;

endmodule

// File: rtl/botones_antirrebote.sv
// Push-button conditioner: N independent debounced channels with
// normalised polarity, press/release pulses and a per-channel toggle.
module botones_antirrebote #(
  parameter int           N               = 4,
  parameter int           DEBOUNCE_CYCLES = 120000,
  parameter logic [N-1:0] ACTIVE_LOW_MASK = 4'b0111
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic [N-1:0] boton,
  output logic [N-1:0] pulsado,
  output logic [N-1:0] flanco_on,
  output logic [N-1:0] flanco_off,
  output logic [N-1:0] conmuta
);

  for (genvar i = 0; i < N; i++) begin : g_canal
    antirrebote_canal #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .ACTIVE_LOW      (ACTIVE_LOW_MASK[i])
    ) u_canal (
      .clk        (clk),
      .rstn       (rstn),
      .boton      (boton[i]),
      .pulsado    (pulsado[i]),
      .flanco_on  (flanco_on[i]),
      .flanco_off (flanco_off[i]),
      .conmuta    (conmuta[i])
    );
  end

endmodule

// File: tb/tb_botones_antirrebote.sv
// Scoreboard bench for botones_antirrebote: a window-based reference model
// predicts every cycle's outputs; a monitor pops and compares them.
module tb_botones_antirrebote;

  localparam int         N   = 4;
  localparam int         DC  = 4;
  localparam logic [3:0] MSK = 4'b0111;
  localparam int         HL  = DC + 2;

  logic       clk;
  logic       rstn;
  logic [3:0] boton;
  logic [3:0] pulsado, flanco_on, flanco_off, conmuta;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [3:0] p;
    logic [3:0] on;
    logic [3:0] off;
    logic [3:0] c;
  } exp_t;

  exp_t exp_q[$];

  botones_antirrebote #(
    .N               (N),
    .DEBOUNCE_CYCLES (DC),
    .ACTIVE_LOW_MASK (MSK)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .boton      (boton),
    .pulsado    (pulsado),
    .flanco_on  (flanco_on),
    .flanco_off (flanco_off),
    .conmuta    (conmuta)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: a level is accepted once the last DC synchronised samples
  // (seen two edges late) all disagree with the current accepted level.
  logic       hist [N][HL];
  logic [3:0] p_m, c_m;

  initial begin
    exp_t e;
    logic flip;
    p_m = 4'b0;
    c_m = 4'b0;
    for (int ch = 0; ch < N; ch++)
      for (int j = 0; j < HL; j++) hist[ch][j] = 1'b0;
    forever begin
      @(posedge clk);
      e = '0;
      if (!rstn) begin
        p_m = 4'b0;
        c_m = 4'b0;
        for (int ch = 0; ch < N; ch++)
          for (int j = 0; j < HL; j++) hist[ch][j] = 1'b0;
      end else begin
        for (int ch = 0; ch < N; ch++) begin
          for (int j = HL - 1; j > 0; j--) hist[ch][j] = hist[ch][j-1];
          hist[ch][0] = boton[ch] ^ MSK[ch];
          flip = 1'b1;
          for (int j = 2; j <= DC + 1; j++)
            if (hist[ch][j] == p_m[ch]) flip = 1'b0;
          if (flip) begin
            e.on[ch]  = ~p_m[ch];
            e.off[ch] = p_m[ch];
            if (!p_m[ch]) c_m[ch] = ~c_m[ch];
            p_m[ch] = ~p_m[ch];
          end
        end
      end
      e.p = p_m;
      e.c = c_m;
      exp_q.push_back(e);
    end
  end

  task automatic cmp(input string name, input logic [3:0] got, input logic [3:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s t=%0t got=%b want=%b", name, $time, got, want);
    end
  endtask

  // Monitor: one expected vector per clock, checked mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL scoreboard_empty t=%0t got=0 want=1", $time);
      end else begin
        e = exp_q.pop_front();
        cmp("pulsado", pulsado, e.p);
        cmp("flanco_on", flanco_on, e.on);
        cmp("flanco_off", flanco_off, e.off);
        cmp("conmuta", conmuta, e.c);
        cmp("on_and_off", flanco_on & flanco_off, 4'b0);
      end
    end
  end

  task automatic drive(input logic [3:0] b, input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      #2 boton = b;
    end
  endtask

  task automatic pulse_reset(input logic [3:0] b_during);
    @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    cmp("async_rst_pulsado", pulsado, 4'b0);
    cmp("async_rst_on", flanco_on, 4'b0);
    cmp("async_rst_off", flanco_off, 4'b0);
    cmp("async_rst_conmuta", conmuta, 4'b0);
    boton = b_during;
    repeat (3) @(negedge clk);
    #2 rstn = 1'b1;
  endtask

  logic [3:0] rb;
  int         hold [N];

  initial begin
    rstn  = 1'b0;
    boton = 4'b0111;
    repeat (3) @(negedge clk);
    #2 rstn = 1'b1;
    drive(4'b0111, 20);
    // ch0 press then release, including a held press
    drive(4'b0110, 10);
    drive(4'b0111, 10);
    // ch1 bounce: 3-cycle lows are rejected, then a steady press
    for (int r = 0; r < 2; r++) begin
      drive(4'b0101, 3);
      drive(4'b0111, 1);
    end
    drive(4'b0101, 8);
    drive(4'b0111, 10);
    // ch3 active-high and ch2 pressed on the same edge
    drive(4'b1011, 10);
    drive(4'b0111, 10);
    // second ch0 press toggles back
    drive(4'b0110, 10);
    drive(4'b0111, 10);
    // reset two samples into a press; released during reset
    drive(4'b0110, 2);
    pulse_reset(4'b0111);
    drive(4'b0111, 12);
    // button held through reset: reported only after debounce
    pulse_reset(4'b0110);
    drive(4'b0110, 10);
    drive(4'b0111, 10);
    // randomized bouncy stimulus
    for (int ch = 0; ch < N; ch++) hold[ch] = 0;
    rb = 4'b0111;
    for (int k = 0; k < 800; k++) begin
      for (int ch = 0; ch < N; ch++) begin
        if (hold[ch] == 0) begin
          rb[ch]   = 1'($urandom_range(0, 1));
          hold[ch] = $urandom_range(1, 8);
        end
        hold[ch]--;
      end
      drive(rb, 1);
      if (k == 400) pulse_reset(rb);
    end
    drive(4'b0111, 12);
    @(negedge clk);
    #3;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/botones_antirrebote.md
Name: botones_antirrebote

Overview:
- Input-side conditioner for the board push-buttons.
- Takes the raw asynchronous button pins and synchronises them to clk.
- Debounces each channel and normalises its polarity.
- Outputs per channel: a clean pressed level, one-cycle press and release pulses, and a toggle register.
- Sits between the button pins and any LED/logic consumer; replaces direct combinational button-to-LED wiring.

Parameters:
- N, 4: number of button channels.
- DEBOUNCE_CYCLES, 120000: consecutive stable cycles needed to accept a new level (10 ms at 12 MHz). Legal range >= 1.
- ACTIVE_LOW_MASK, 4'b0111: bit i = 1 means pin i reads 0 when pressed; bit i = 0 means active-high. Width N.

Ports:
- clk  input  1  system clock; single clock domain.
- rstn  input  1  asynchronous, active-low reset.
- boton  input  N  raw button pins, asynchronous to clk.
- pulsado  output  N  debounced level; 1 = pressed, polarity already normalised.
- flanco_on  output  N  one-cycle pulse on an accepted press.
- flanco_off  output  N  one-cycle pulse on an accepted release.
- conmuta  output  N  toggles on every accepted press; suitable to drive an LED directly.

Behaviour:
- Reset (rstn = 0, asynchronous assert; deassertion sampled on clk):
  - pulsado, flanco_on, flanco_off, conmuta = 0.
  - Debounce counters = 0.
  - Both synchroniser stages load the released level for each channel (ACTIVE_LOW_MASK[i] for channel i). A button held through reset therefore produces no pulse at reset release; it is reported as a press only after the normal debounce time.
- Synchroniser: two flops per channel.
  - Normalised sample n[i] = s2[i] XOR ACTIVE_LOW_MASK[i].
- Debounce, per channel, independent of the others. Counter width = clog2(DEBOUNCE_CYCLES+1).
  - If n[i] == pulsado[i]: counter cleared.
  - If n[i] != pulsado[i] and counter < DEBOUNCE_CYCLES-1: counter increments.
  - If n[i] != pulsado[i] and counter == DEBOUNCE_CYCLES-1:
    - pulsado[i] flips and counter clears.
    - flanco_on[i] = 1 (rising) or flanco_off[i] = 1 (falling) for exactly that one cycle.
    - conmuta[i] inverts on the rising case only.
- Any single matching sample (a bounce) restarts the count. A glitch shorter than DEBOUNCE_CYCLES never changes any output.
- Latency: take the first clk edge that samples the new raw level as edge 0. pulsado, the pulse and conmuta all update at edge DEBOUNCE_CYCLES+1 (2-stage synchroniser, then DEBOUNCE_CYCLES mismatching samples).
- flanco_on and flanco_off are registered, never both high on one channel, and never high in two consecutive cycles on one channel. The minimum spacing between pulses on one channel is DEBOUNCE_CYCLES cycles.
- Channels acting simultaneously produce simultaneous pulses; there is no arbitration.
- DEBOUNCE_CYCLES = 1: pulsado follows n with one cycle of extra delay, and every change is accepted.
- Reset mid-count: the count is discarded and all outputs return to 0 immediately (asynchronous).
- No combinational path from boton to any output.

Decomposition:
- No shared package needed. Counter width and the released-level constant are derived locally from the parameters.
- One natural sub-module, antirrebote_canal: a single-channel synchroniser, counter and edge/toggle logic, with parameters DEBOUNCE_CYCLES and ACTIVE_LOW.
- Top level instantiates N of them in a generate loop, slicing ACTIVE_LOW_MASK per instance.

Test Plan:
All scenarios use DEBOUNCE_CYCLES = 4, N = 4, ACTIVE_LOW_MASK = 4'b0111.
- Reset idle: hold boton = 4'b0111 through and after reset -> all outputs stay 0 for 20 cycles.
- Clean press on ch0: boton[0] 1->0 sampled at edge 0 -> pulsado[0] = 1 and flanco_on[0] = 1 at edge 5; flanco_on[0] = 0 at edge 6; conmuta[0] = 1.
- Release after 10 cycles held -> flanco_off[0] pulses once, 5 edges after the first sampling edge. pulsado[0] = 0; conmuta[0] stays 1.
- Bounce rejection: ch1 pattern 0,0,0,1,0,0,0,1 (3-cycle lows) -> no output change. A following steady 0 for 4+ samples -> exactly one flanco_on[1].
- Active-high ch3 plus simultaneity: boton[3] 0->1 and boton[2] 1->0 on the same edge -> flanco_on[3] and flanco_on[2] pulse in the same cycle.
- Second press on ch0 -> conmuta[0] returns to 0. Asserting rstn = 0 mid-count (2 samples into a press) -> outputs 0 at once, no pulse after release.
